// File: rtl/viol_log_pkg.sv
// viol_log_pkg: shared types and field layout for the violation reset/log controller.
//   - FSM state encoding
//   - context payload struct and field widths/offsets of a log entry
//   - entry_w(): log entry width for a given number of monitor channels
// Build option: define VIOL_LOG_TIMESTAMP_EN to append a 16-bit cycle stamp to each entry.
package viol_log_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } fsm_state_e;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned CAUSE_W = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TS_W    = 16;

`ifdef VIOL_LOG_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Bits the timestamp occupies at the bottom of an entry (0 when disabled)
    localparam int unsigned TS_FIELD_W = TS_EN ? TS_W : 0;

    // CPU/DMA context captured with each incident
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] data_addr;
        logic [ADDR_W-1:0] dma_addr;
        logic              data_en;
        logic              data_wr;
        logic              dma_en;
    } ctx_t;

    localparam int unsigned CTX_W = $bits(ctx_t);

    // Entry layout, LSB first: [ts] ctx cause viol
    localparam int unsigned CTX_OFF   = TS_FIELD_W;
    localparam int unsigned CAUSE_OFF = CTX_OFF + CTX_W;
    localparam int unsigned VIOL_OFF  = CAUSE_OFF + CAUSE_W;

    function automatic int unsigned entry_w(input int unsigned num_ch);
        return num_ch + CAUSE_W + CTX_W + TS_FIELD_W;
    endfunction

endpackage

// File: rtl/viol_fifo.sv
// viol_fifo: synchronous first-word-fall-through FIFO for log entries.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous flush (takes precedence over wr_en/rd_en)
//   wr_en/wr_data write request and payload (ignored when full unless popping)
//   rd_en         consume head entry (ignored when empty)
//   rd_data       head entry, valid while rd_valid
//   rd_valid      FIFO not empty
//   full          FIFO holds DEPTH entries
module viol_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer MSB distinguishes full from empty
    assign rd_valid = (wr_ptr_q != rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_rd = rd_en & rd_valid;
    // A write into a full FIFO is legal only when the head leaves in the same cycle
    assign do_wr = wr_en & (~full | do_rd);

    assign rd_data = mem[rd_ptr_q[AW-1:0]];

    // Storage: no reset needed, validity tracked by the pointers
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/viol_log_ctrl.sv
// viol_log_ctrl: turns violation-monitor requests into a CPU reset of guaranteed
// minimum length and logs one context entry per incident into a FIFO.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   viol[NUM_CH]                  monitor reset requests (bit 0 = highest priority)
//   pc, data_addr, dma_addr       CPU/DMA context captured on an incident
//   data_en, data_wr, dma_en      bus qualifiers captured on an incident
//   clr_log                       flush log, overflow state and incident mask
//   reset                         CPU reset request (combinational with viol)
//   rd_valid/rd_ready/rd_data     log read port (first-word-fall-through)
//   overflow, drop_cnt            sticky drop flag and saturating drop count
//   incident_mask                 sticky OR of viol since the last clr_log
// Build option: VIOL_LOG_TIMESTAMP_EN appends a free-running 16-bit cycle
// counter as the entry LSBs.
module viol_log_ctrl
    import viol_log_pkg::*;
#(
    parameter int unsigned NUM_CH        = 6,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned HOLD_CYCLES   = 4,
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    localparam int unsigned ENTRY_W      = entry_w(NUM_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  viol,
    input  logic [15:0]        pc,
    input  logic [15:0]        data_addr,
    input  logic [15:0]        dma_addr,
    input  logic               data_en,
    input  logic               data_wr,
    input  logic               dma_en,
    input  logic               clr_log,
    output logic               reset,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               overflow,
    output logic [7:0]         drop_cnt,
    output logic [NUM_CH-1:0]  incident_mask
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    fsm_state_e         state_q;
    fsm_state_e         state_d;
    logic [CNT_W-1:0]   hold_cnt_q;
    logic [CNT_W-1:0]   hold_cnt_d;
    logic               any_viol;
    logic               push_req;
    logic               log_push;
    logic               pop;
    logic               wr_en;
    logic               drop;
    logic               fifo_full;
    logic [CAUSE_W-1:0] cause_idx;
    ctx_t               ctx;
    logic [ENTRY_W-1:0] entry;

    assign any_viol = |viol;

    // Reset follows viol immediately; FSM keeps it up afterwards. rst masks the FSM term.
    assign reset = any_viol | (~rst & (state_q != ST_IDLE));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // FSM next state; a new incident is recognised only when leaving IDLE
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        push_req   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_viol) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                    push_req   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (any_viol) begin
                    hold_cnt_d = HOLD_LOAD;
                end else if (hold_cnt_q == '0) begin
                    state_d = ST_RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (any_viol) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end else if (pc == RESET_HANDLER) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Lowest set viol index wins: scan from the top so bit 0 overrides last
    always_comb begin
        cause_idx = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (viol[i]) begin
                cause_idx = CAUSE_W'(i);
            end
        end
    end

    // Context payload
    always_comb begin
        ctx.pc        = pc;
        ctx.data_addr = data_addr;
        ctx.dma_addr  = dma_addr;
        ctx.data_en   = data_en;
        ctx.data_wr   = data_wr;
        ctx.dma_en    = dma_en;
    end

`ifdef VIOL_LOG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running cycle stamp, wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign entry = {viol, cause_idx, ctx, ts_q};
`else
    assign entry = {viol, cause_idx, ctx};
`endif

    // Log write control: clr_log discards a coincident push; a pop frees room for it
    assign pop      = rd_valid & rd_ready;
    assign log_push = push_req & ~clr_log & ~rst;
    assign wr_en    = log_push & (~fifo_full | pop);
    assign drop     = log_push & fifo_full & ~pop;

    viol_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_log),
        .wr_en    (wr_en),
        .wr_data  (entry),
        .rd_en    (pop),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (fifo_full)
    );

    // Sticky status: overflow flag, saturating drop count, incident mask
    always_ff @(posedge clk) begin
        if (rst || clr_log) begin
            overflow      <= 1'b0;
            drop_cnt      <= '0;
            incident_mask <= '0;
        end else begin
            incident_mask <= incident_mask | viol;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 8'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_viol_log_ctrl.sv
// tb_viol_log_ctrl: directed incident scenarios plus randomized traffic checked
// against a time-based reference model (reset stays busy until HOLD_CYCLES after
// the last violation and then until the CPU reaches the handler PC).
`timescale 1ns/1ps
module tb_viol_log_ctrl;

    localparam int unsigned NUM_CH  = 6;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned HOLD    = 4;
    localparam logic [15:0] HANDLER = 16'h0000;
`ifdef VIOL_LOG_TIMESTAMP_EN
    localparam int unsigned TSW = 16;
`else
    localparam int unsigned TSW = 0;
`endif
    localparam int unsigned EW        = NUM_CH + 55 + TSW;
    localparam int unsigned PC_LSB    = TSW + 35;
    localparam int unsigned CAUSE_LSB = TSW + 51;
    localparam int unsigned VIOL_LSB  = TSW + 55;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] viol;
    logic [15:0]       pc;
    logic [15:0]       data_addr;
    logic [15:0]       dma_addr;
    logic              data_en;
    logic              data_wr;
    logic              dma_en;
    logic              clr_log;
    logic              reset;
    logic              rd_valid;
    logic              rd_ready;
    logic [EW-1:0]     rd_data;
    logic              overflow;
    logic [7:0]        drop_cnt;
    logic [NUM_CH-1:0] incident_mask;

    viol_log_ctrl #(
        .NUM_CH        (NUM_CH),
        .DEPTH         (DEPTH),
        .HOLD_CYCLES   (HOLD),
        .RESET_HANDLER (HANDLER)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .viol          (viol),
        .pc            (pc),
        .data_addr     (data_addr),
        .dma_addr      (dma_addr),
        .data_en       (data_en),
        .data_wr       (data_wr),
        .dma_en        (dma_en),
        .clr_log       (clr_log),
        .reset         (reset),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt),
        .incident_mask (incident_mask)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    bit                m_active;
    int                m_last;
    int                m_cyc;
    logic [EW-1:0]     m_q[$];
    bit                m_ovf;
    int                m_drop;
    logic [NUM_CH-1:0] m_mask;
`ifdef VIOL_LOG_TIMESTAMP_EN
    logic [15:0]       m_ts;
`endif
    logic              exp_reset;

    // Apply inputs just after a falling edge and compute the expected reset level
    task automatic drive(input logic [NUM_CH-1:0] v, input logic [15:0] p,
                         input logic rr, input logic cl, input logic r);
        viol      = v;
        pc        = p;
        rd_ready  = rr;
        clr_log   = cl;
        rst       = r;
        data_addr = 16'($urandom);
        dma_addr  = 16'($urandom);
        data_en   = 1'($urandom);
        data_wr   = 1'($urandom);
        dma_en    = 1'($urandom);
        #1;
        exp_reset = (v != '0) || (!r && m_active);
    endtask

    // Advance the model by one clock using the current inputs, then move to the next falling edge
    task automatic advance();
        logic [EW-1:0] e;
        int            cause;
        bit            pop;
        bit            push;
        cause = -1;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (viol[i] && cause < 0) cause = i;
        end
        if (cause < 0) cause = 0;
`ifdef VIOL_LOG_TIMESTAMP_EN
        e = {viol, 4'(cause), pc, data_addr, dma_addr, data_en, data_wr, dma_en, m_ts};
`else
        e = {viol, 4'(cause), pc, data_addr, dma_addr, data_en, data_wr, dma_en};
`endif
        pop  = (m_q.size() > 0) && rd_ready;
        push = !m_active && (viol != '0);
        if (rst) begin
            m_active = 1'b0;
            m_q.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
            m_mask = '0;
`ifdef VIOL_LOG_TIMESTAMP_EN
            m_ts   = '0;
`endif
        end else begin
            if (viol != '0) begin
                m_active = 1'b1;
                m_last   = m_cyc;
            end else if (m_active && (m_cyc >= m_last + int'(HOLD) + 1) && pc == HANDLER) begin
                m_active = 1'b0;
            end
            if (clr_log) begin
                m_q.delete();
                m_ovf  = 1'b0;
                m_drop = 0;
                m_mask = '0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    if (m_q.size() < int'(DEPTH)) m_q.push_back(e);
                    else begin
                        m_ovf = 1'b1;
                        if (m_drop < 255) m_drop++;
                    end
                end
                m_mask = m_mask | viol;
            end
`ifdef VIOL_LOG_TIMESTAMP_EN
            m_ts = m_ts + 16'd1;
`endif
        end
        m_cyc++;
        @(negedge clk);
    endtask

    // One incident: violation cycle, HOLD cycles off-handler, one RELEASE cycle at the handler
    task automatic run_incident(input logic [NUM_CH-1:0] v, input logic [15:0] p, input logic rr);
        drive(v, p, rr, 1'b0, 1'b0);
        advance();
        repeat (HOLD) begin
            drive('0, 16'h1111, 1'b0, 1'b0, 1'b0);
            advance();
        end
        drive('0, HANDLER, 1'b0, 1'b0, 1'b0);
        advance();
    endtask

    task automatic test_reset();
        drive(6'b000011, 16'h5555, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (reset !== 1'b1) begin miscompares++; $display("FAIL rst_reset_follows_viol: got %b want 1", reset); end
        vectors++;
        if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
        vectors++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            miscompares++; $display("FAIL rst_overflow: got ovf=%b drop=%0d want 0/0", overflow, drop_cnt);
        end
        vectors++;
        if (incident_mask !== '0) begin miscompares++; $display("FAIL rst_mask: got %b want 0", incident_mask); end
        advance();
        drive('0, 16'h5555, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (reset !== 1'b0) begin miscompares++; $display("FAIL rst_reset_quiet: got %b want 0", reset); end
        advance();
        drive('0, 16'h5555, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (reset !== 1'b0 || rd_valid !== 1'b0) begin
            miscompares++; $display("FAIL post_rst_idle: got reset=%b rd_valid=%b want 0/0", reset, rd_valid);
        end
        advance();
    endtask

    task automatic test_single_incident();
        logic [EW-1:0] d;
        drive(6'b000100, 16'hA010, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (reset !== 1'b1) begin miscompares++; $display("FAIL single_reset_comb: got %b want 1", reset); end
        advance();
        for (int j = 1; j <= 8; j++) begin
            drive('0, (j >= 7) ? 16'h0000 : 16'hA010, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (reset !== (j <= 7)) begin
                miscompares++; $display("FAIL single_reset_len cyc%0d: got %b want %b", j, reset, (j <= 7));
            end
            if (j == 1) begin
                d = rd_data;
                vectors++;
                if (rd_valid !== 1'b1 || d[CAUSE_LSB +: 4] !== 4'd2 || d[PC_LSB +: 16] !== 16'hA010 ||
                    d[VIOL_LSB +: NUM_CH] !== 6'b000100) begin
                    miscompares++;
                    $display("FAIL single_entry: got valid=%b cause=%0d pc=%h viol=%b want 1/2/a010/000100",
                             rd_valid, d[CAUSE_LSB +: 4], d[PC_LSB +: 16], d[VIOL_LSB +: NUM_CH]);
                end
                vectors++;
                if (incident_mask !== 6'b000100) begin
                    miscompares++; $display("FAIL single_mask: got %b want 000100", incident_mask);
                end
            end
            advance();
        end
        drive('0, 16'h0000, 1'b1, 1'b0, 1'b0);
        advance();
        drive('0, 16'h0000, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL single_one_entry: got rd_valid=%b want 0", rd_valid); end
        advance();
    endtask

    task automatic test_rehold();
        logic [EW-1:0] d;
        drive(6'b100001, 16'h0B00, 1'b0, 1'b0, 1'b0);
        advance();
        drive('0, 16'h0B00, 1'b0, 1'b0, 1'b0);
        d = rd_data;
        vectors++;
        if (rd_valid !== 1'b1 || d[CAUSE_LSB +: 4] !== 4'd0 || d[VIOL_LSB +: NUM_CH] !== 6'b100001) begin
            miscompares++;
            $display("FAIL rehold_entry: got valid=%b cause=%0d viol=%b want 1/0/100001",
                     rd_valid, d[CAUSE_LSB +: 4], d[VIOL_LSB +: NUM_CH]);
        end
        advance();
        drive('0, 16'h0B00, 1'b0, 1'b0, 1'b0);
        advance();
        drive(6'b000010, 16'h0B00, 1'b0, 1'b0, 1'b0);
        advance();
        for (int j = 1; j <= 6; j++) begin
            drive('0, 16'h0000, (j == 1), 1'b0, 1'b0);
            vectors++;
            if (reset !== (j <= 5)) begin
                miscompares++; $display("FAIL rehold_restart cyc%0d: got %b want %b", j, reset, (j <= 5));
            end
            vectors++;
            if (rd_valid !== (j == 1)) begin
                miscompares++; $display("FAIL rehold_no_new_entry cyc%0d: got %b want %b", j, rd_valid, (j == 1));
            end
            if (j == 1) begin
                vectors++;
                if (incident_mask !== 6'b100111) begin
                    miscompares++; $display("FAIL rehold_mask: got %b want 100111", incident_mask);
                end
            end
            advance();
        end
    endtask

    task automatic test_overflow();
        logic [EW-1:0] d;
        drive('0, 16'h0000, 1'b0, 1'b1, 1'b0);
        advance();
        for (int k = 0; k < 17; k++) run_incident(NUM_CH'(1 << (k % 6)), 16'(k + 1), 1'b0);
        drive('0, 16'h0000, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
            miscompares++; $display("FAIL ovf_drop: got ovf=%b drop=%0d want 1/1", overflow, drop_cnt);
        end
        advance();
        for (int k = 0; k < 16; k++) begin
            drive('0, 16'h0000, 1'b1, 1'b0, 1'b0);
            d = rd_data;
            vectors++;
            if (rd_valid !== 1'b1 || d[PC_LSB +: 16] !== 16'(k + 1)) begin
                miscompares++; $display("FAIL ovf_entry%0d: got valid=%b pc=%h want 1/%h", k, rd_valid, d[PC_LSB +: 16], 16'(k + 1));
            end
            advance();
        end
        drive('0, 16'h0000, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_sixteen_only: got rd_valid=%b want 0", rd_valid); end
        advance();
        for (int k = 0; k < 16; k++) run_incident(6'b000001, 16'(k + 1), 1'b0);
        run_incident(6'b000001, 16'd17, 1'b1);
        drive('0, 16'h0000, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            miscompares++; $display("FAIL full_push_pop: got ovf=%b drop=%0d want 0/0", overflow, drop_cnt);
        end
        advance();
        for (int k = 0; k < 16; k++) begin
            drive('0, 16'h0000, 1'b1, 1'b0, 1'b0);
            d = rd_data;
            vectors++;
            if (rd_valid !== 1'b1 || d[PC_LSB +: 16] !== 16'(k + 2)) begin
                miscompares++; $display("FAIL pushpop_entry%0d: got valid=%b pc=%h want 1/%h", k, rd_valid, d[PC_LSB +: 16], 16'(k + 2));
            end
            advance();
        end
    endtask

    task automatic test_clr_same_cycle();
        run_incident(6'b000001, 16'h0C01, 1'b0);
        drive(6'b001000, 16'h0C00, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (reset !== 1'b1) begin miscompares++; $display("FAIL clr_reset_comb: got %b want 1", reset); end
        advance();
        drive('0, 16'h0C00, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (rd_valid !== 1'b0 || drop_cnt !== 8'd0 || incident_mask !== '0) begin
            miscompares++;
            $display("FAIL clr_flush: got valid=%b drop=%0d mask=%b want 0/0/0", rd_valid, drop_cnt, incident_mask);
        end
        vectors++;
        if (reset !== 1'b1) begin miscompares++; $display("FAIL clr_fsm_kept: got %b want 1", reset); end
        advance();
        repeat (4) begin
            drive('0, 16'h0000, 1'b0, 1'b0, 1'b0);
            advance();
        end
        drive('0, 16'h0000, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (reset !== 1'b0) begin miscompares++; $display("FAIL clr_release: got %b want 0", reset); end
        advance();
    endtask

    task automatic test_rst_in_release();
        drive(6'b010000, 16'h0D00, 1'b0, 1'b0, 1'b0);
        advance();
        repeat (HOLD) begin
            drive('0, 16'h0D00, 1'b0, 1'b0, 1'b0);
            advance();
        end
        drive('0, 16'h0D00, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (reset !== 1'b1) begin miscompares++; $display("FAIL release_reset: got %b want 1", reset); end
        advance();
        drive('0, 16'h0D00, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (reset !== 1'b0) begin miscompares++; $display("FAIL rst_masks_fsm: got %b want 0", reset); end
        advance();
        drive('0, 16'h0D00, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (reset !== 1'b0 || rd_valid !== 1'b0 || incident_mask !== '0) begin
            miscompares++;
            $display("FAIL rst_abort: got reset=%b valid=%b mask=%b want 0/0/0", reset, rd_valid, incident_mask);
        end
        advance();
    endtask

`ifdef VIOL_LOG_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [15:0] t0;
        logic [15:0] t1;
        drive('0, 16'h0000, 1'b0, 1'b1, 1'b0);
        advance();
        run_incident(6'b000001, 16'h0E00, 1'b0);
        repeat (54) begin
            drive('0, 16'h0000, 1'b0, 1'b0, 1'b0);
            advance();
        end
        run_incident(6'b000010, 16'h0E01, 1'b0);
        drive('0, 16'h0000, 1'b1, 1'b0, 1'b0);
        t0 = rd_data[15:0];
        advance();
        drive('0, 16'h0000, 1'b1, 1'b0, 1'b0);
        t1 = rd_data[15:0];
        vectors++;
        if (16'(t1 - t0) !== 16'd60) begin
            miscompares++; $display("FAIL ts_delta: got %0d want 60", 16'(t1 - t0));
        end
        advance();
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            logic [NUM_CH-1:0] v;
            logic [15:0]       p;
            logic              rr;
            v  = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
            p  = ($urandom_range(0, 3) == 0) ? HANDLER : 16'($urandom);
            rr = (((n / 400) % 2) == 1) ? ($urandom_range(0, 29) == 0) : 1'($urandom);
            drive(v, p, rr, ($urandom_range(0, 299) == 0), ($urandom_range(0, 499) == 0));
            vectors++;
            if (reset !== exp_reset) begin
                miscompares++; $display("FAIL rand_reset n=%0d: got %b want %b", n, reset, exp_reset);
            end
            vectors++;
            if (rd_valid !== (m_q.size() > 0)) begin
                miscompares++; $display("FAIL rand_rd_valid n=%0d: got %b want %b", n, rd_valid, (m_q.size() > 0));
            end
            if (m_q.size() > 0) begin
                vectors++;
                if (rd_data !== m_q[0]) begin
                    miscompares++; $display("FAIL rand_rd_data n=%0d: got %h want %h", n, rd_data, m_q[0]);
                end
            end
            vectors++;
            if (overflow !== m_ovf || drop_cnt !== 8'(m_drop)) begin
                miscompares++;
                $display("FAIL rand_overflow n=%0d: got ovf=%b drop=%0d want %b/%0d", n, overflow, drop_cnt, m_ovf, m_drop);
            end
            vectors++;
            if (incident_mask !== m_mask) begin
                miscompares++; $display("FAIL rand_mask n=%0d: got %b want %b", n, incident_mask, m_mask);
            end
            advance();
        end
    endtask

    initial begin
        m_active = 1'b0;
        m_last   = 0;
        m_cyc    = 0;
        m_ovf    = 1'b0;
        m_drop   = 0;
        m_mask   = '0;
`ifdef VIOL_LOG_TIMESTAMP_EN
        m_ts     = '0;
`endif
        rst = 1'b1; viol = '0; pc = '0; data_addr = '0; dma_addr = '0;
        data_en = 1'b0; data_wr = 1'b0; dma_en = 1'b0; clr_log = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_incident();
        test_rehold();
        test_overflow();
        test_clr_same_cycle();
        test_rst_in_release();
`ifdef VIOL_LOG_TIMESTAMP_EN
        test_timestamp();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
